tuner_iq_sched: RTL and testbench

Time-shares one `tuner_mixer` instance between the I (cos) and Q (sin) products of each input sample. It owns the NCO phase accumulator and drives the mixer's `cos`, `phs` and `in` ports. It tracks the mixer's fixed pipeline latency and reassembles each result pair into one I/Q output beat. The block sits between the ADC sample stream and the decimation chain, and applies frequency and phase commands only on sample boundaries so that retunes are phase-continuous.

---
 rtl/tuner_iq_sched_if.sv | 53 +++++
 rtl/tuner_iq_sched.sv | 172 +++++++++++++++++
 tb/tb_tuner_iq_sched.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tuner_iq_sched_if.sv
// ---------------------------------------------------------------------------
// tuner_iq_sched_if
//   Bundles every non-clock/reset signal of tuner_iq_sched.
//
//   Modports:
//     master : the scheduler side. It drives s_ready, cfg_pending, the mixer
//              controls (mix_cos/mix_phs/mix_in), the result beat
//              (m_valid/m_i/m_q) and the state_dbg observation bit.
//     slave  : the environment side (sample source, control plane, mixer,
//              decimation chain). It drives enable, s_valid/s_data, the
//              cfg_* commands and mix_out.
//
//   Handshake: a sample transfers on a cycle where s_valid and s_ready are
//   both high. s_valid may rise or fall on any cycle. s_ready may depend
//   combinationally on enable but never on s_valid. The output side has no
//   back-pressure, so m_valid is a one-cycle pulse.
// ---------------------------------------------------------------------------
interface tuner_iq_sched_if #(
    parameter int DSZ = 16,
    parameter int PSZ = 12,
    parameter int ASZ = 32
);
    logic           enable;
    logic           s_valid;
    logic [DSZ-1:0] s_data;
    logic           s_ready;
    logic [ASZ-1:0] cfg_fword;
    logic           cfg_load;
    logic           cfg_phase_clr;
    logic           cfg_pending;
    logic           mix_cos;
    logic [PSZ-1:0] mix_phs;
    logic [DSZ-1:0] mix_in;
    logic [DSZ-1:0] mix_out;
    logic           m_valid;
    logic [DSZ-1:0] m_i;
    logic [DSZ-1:0] m_q;
    logic           state_dbg;   // 0 = ISSUE_I, 1 = ISSUE_Q

    modport master (
        input  enable, s_valid, s_data, cfg_fword, cfg_load, cfg_phase_clr,
               mix_out,
        output s_ready, cfg_pending, mix_cos, mix_phs, mix_in, m_valid, m_i,
               m_q, state_dbg
    );

    modport slave (
        output enable, s_valid, s_data, cfg_fword, cfg_load, cfg_phase_clr,
               mix_out,
        input  s_ready, cfg_pending, mix_cos, mix_phs, mix_in, m_valid, m_i,
               m_q, state_dbg
    );
endinterface

// File: rtl/tuner_iq_sched.sv
// ---------------------------------------------------------------------------
// tuner_iq_sched
//   Time-shares one external tuner_mixer between the I (cos) and Q (sin)
//   products of each input sample. Owns the NCO phase accumulator, drives the
//   mixer's cos/phs/in inputs, tracks the mixer's fixed pipeline latency and
//   reassembles each I/Q result pair into one output beat. Frequency and
//   phase commands take effect only on sample boundaries so retunes are
//   phase-continuous.
//
//   Ports:
//     clk    : clock
//     reset  : asynchronous, active-high reset
//     bus    : tuner_iq_sched_if.master
//              enable, s_valid/s_data/s_ready : sample input handshake
//              cfg_fword/cfg_load/cfg_phase_clr/cfg_pending : retune control
//              mix_cos/mix_phs/mix_in/mix_out : shared mixer connection
//              m_valid/m_i/m_q                : I/Q result beat
//              state_dbg                      : current FSM state
//
//   Timing (A = accept cycle):
//     A, A+1   : mixer phase issued for I then Q (same phase word)
//     A+4, A+5 : sample presented on mix_in (mixer phase-to-LO latency is 4)
//     A+6, A+7 : mix_out carries the I then Q product
//     A+8      : m_valid pulse with the pair registered
// ---------------------------------------------------------------------------
module tuner_iq_sched #(
    parameter int DSZ = 16,
    parameter int PSZ = 12,
    parameter int ASZ = 32
) (
    input  logic           clk,
    input  logic           reset,
    tuner_iq_sched_if.master bus
);

    typedef enum logic {
        ISSUE_I = 1'b0,
        ISSUE_Q = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ASZ-1:0]      acc_q, acc_d;
    logic [ASZ-1:0]      fword_act_q, fword_act_d;
    logic [ASZ-1:0]      fword_pend_q, fword_pend_d;
    logic                load_pend_q, load_pend_d;
    logic                clr_pend_q, clr_pend_d;
    logic [3:0][DSZ-1:0] dly_q, dly_d;
    logic [6:0]          tag_q, tag_d;
    logic                m_valid_q, m_valid_d;
    logic [DSZ-1:0]      m_i_q, m_i_d;
    logic [DSZ-1:0]      m_q_q, m_q_d;

    logic                s_ready;
    logic                accept;
    logic                app_pt;
    logic [DSZ-1:0]      dly_head;

    assign s_ready = (state_q == ISSUE_I) && bus.enable;
    assign accept  = bus.s_valid && s_ready;
    // Commands apply when leaving ISSUE_Q or when idling in ISSUE_I. Since
    // accept is never true in ISSUE_Q this is exactly "no accept this cycle".
    assign app_pt  = !accept;

    // The sample enters the line on accept and is re-entered during ISSUE_Q,
    // so each sample occupies two consecutive slots of the 4-deep line and
    // appears on mix_in for two cycles. Idle slots carry zero.
    always_comb begin
        dly_head = '0;
        if (accept) begin
            dly_head = bus.s_data;
        end else if (state_q == ISSUE_Q) begin
            dly_head = dly_q[0];
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        fword_act_d  = fword_act_q;
        fword_pend_d = fword_pend_q;
        load_pend_d  = load_pend_q;
        clr_pend_d   = clr_pend_q;

        case (state_q)
            ISSUE_I: if (accept) state_d = ISSUE_Q;
            ISSUE_Q: state_d = ISSUE_I;
            default: state_d = ISSUE_I;
        endcase

        // Last load wins; the pending word is only consumed on application.
        if (bus.cfg_load) begin
            fword_pend_d = bus.cfg_fword;
        end

        if (app_pt) begin
            // Increment uses the word active before this edge; a pending
            // clear overrides it so the next sample starts at phase zero.
            if (state_q == ISSUE_Q) begin
                acc_d = acc_q + fword_act_q;
            end
            if (clr_pend_q) begin
                acc_d = '0;
            end
            if (load_pend_q) begin
                fword_act_d = fword_pend_q;
            end
            // A command landing on the application edge waits for the next one.
            load_pend_d = bus.cfg_load;
            clr_pend_d  = bus.cfg_phase_clr;
        end else begin
            load_pend_d = load_pend_q || bus.cfg_load;
            clr_pend_d  = clr_pend_q || bus.cfg_phase_clr;
        end
    end

    // Result capture: tag bit k is high during cycle A+1+k. m_valid_q acts as
    // the eighth tag stage.
    always_comb begin
        dly_d     = {dly_q[2:0], dly_head};
        tag_d     = {tag_q[5:0], accept};
        m_i_d     = m_i_q;
        m_q_d     = m_q_q;
        m_valid_d = tag_q[6];
        if (tag_q[5]) begin
            m_i_d = bus.mix_out;
        end
        if (tag_q[6]) begin
            m_q_d = bus.mix_out;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ISSUE_I;
            acc_q        <= '0;
            fword_act_q  <= '0;
            fword_pend_q <= '0;
            load_pend_q  <= 1'b0;
            clr_pend_q   <= 1'b0;
            dly_q        <= '0;
            tag_q        <= '0;
            m_valid_q    <= 1'b0;
            m_i_q        <= '0;
            m_q_q        <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            fword_act_q  <= fword_act_d;
            fword_pend_q <= fword_pend_d;
            load_pend_q  <= load_pend_d;
            clr_pend_q   <= clr_pend_d;
            dly_q        <= dly_d;
            tag_q        <= tag_d;
            m_valid_q    <= m_valid_d;
            m_i_q        <= m_i_d;
            m_q_q        <= m_q_d;
        end
    end

    // Phase comes straight from the accumulator register, so it is stable
    // across both issue cycles of a sample.
    assign bus.s_ready     = s_ready;
    assign bus.cfg_pending = load_pend_q || clr_pend_q;
    assign bus.mix_cos     = (state_q == ISSUE_I);
    assign bus.mix_phs     = acc_q[ASZ-1 -: PSZ];
    assign bus.mix_in      = dly_q[3];
    assign bus.m_valid     = m_valid_q;
    assign bus.m_i         = m_i_q;
    assign bus.m_q         = m_q_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_tuner_iq_sched.sv
module tb_tuner_iq_sched;

    localparam logic [15:0] DV  = 16'h4000;
    localparam logic [15:0] PI  = 16'd16383;
    localparam logic [15:0] NI  = 16'hC000;     // -16384
    localparam logic [31:0] F4  = 32'h4000_0000;
    localparam logic [31:0] F2  = 32'h2000_0000;
    localparam logic [31:0] F1  = 32'h1000_0000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    int   checks   = 0;
    int   failures = 0;
    int   mv_count = 0;
    logic sb_data  = 1'b0;
    logic [31:0] exp_acc = '0;

    logic [31:0] exp_cyc_q[$];
    logic [31:0] exp_q[$];

    tuner_iq_sched_if #(.DSZ(16), .PSZ(12), .ASZ(32)) bus ();

    tuner_iq_sched #(.DSZ(16), .PSZ(12), .ASZ(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- mixer model ----------------
    // Quadrant-exact LO, 4-cycle phase-to-LO latency, two product registers.
    function automatic logic signed [15:0] lo_val(input logic [1:0] quad, input logic is_cos);
        logic signed [15:0] v;
        case (quad)
            2'd0: v = is_cos ? 16'sd32767  : 16'sd0;
            2'd1: v = is_cos ? 16'sd0      : 16'sd32767;
            2'd2: v = is_cos ? -16'sd32767 : 16'sd0;
            default: v = is_cos ? 16'sd0   : -16'sd32767;
        endcase
        return v;
    endfunction

    function automatic logic [15:0] prod(input logic signed [15:0] d, input logic signed [15:0] lo);
        logic signed [31:0] p;
        p = d * lo;
        return p[30:15];
    endfunction

    logic signed [15:0] lo_pipe[4] = '{default: '0};
    logic [15:0] p1 = '0;
    logic [15:0] p2 = '0;
    always @(posedge clk) begin
        lo_pipe[0] <= lo_val(bus.mix_phs[11:10], bus.mix_cos);
        for (int k = 1; k < 4; k++) lo_pipe[k] <= lo_pipe[k-1];
        p1 <= prod(bus.mix_in, lo_pipe[3]);
        p2 <= p1;
    end
    assign bus.mix_out = p2;

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sv, input logic [15:0] sd, input logic ld,
                         input logic [31:0] fw, input logic clr, input logic en);
        @(negedge clk);
        bus.s_valid       = sv;
        bus.s_data        = sd;
        bus.cfg_load      = ld;
        bus.cfg_fword     = fw;
        bus.cfg_phase_clr = clr;
        bus.enable        = en;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    // Scoreboard: records accepts, expects m_valid 8 cycles later with the
    // pair the mixer model produces for the bench-tracked phase.
    task automatic observe();
        logic [1:0] q;
        logic [31:0] c;
        logic [31:0] d;
        if (bus.s_valid && bus.s_ready) begin
            q = exp_acc[31:30];
            exp_cyc_q.push_back(32'(cyc + 8));
            exp_q.push_back({prod(bus.s_data, lo_val(q, 1'b1)), prod(bus.s_data, lo_val(q, 1'b0))});
            exp_acc = exp_acc + F4;
        end
        if (bus.m_valid) begin
            mv_count++;
            checks++;
            if (exp_cyc_q.size() == 0) begin
                failures++;
                $display("FAIL m_valid unexpected: got pulse at cycle %0d expected none", cyc);
            end else begin
                c = exp_cyc_q.pop_front();
                d = exp_q.pop_front();
                check("m_valid latency", 32'(cyc), c);
                if (sb_data) check("result pair", {bus.m_i, bus.m_q}, d);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " s_ready"},     32'(bus.s_ready),     32'd1);
        check({tag, " mix_cos"},     32'(bus.mix_cos),     32'd1);
        check({tag, " mix_phs"},     32'(bus.mix_phs),     32'd0);
        check({tag, " mix_in"},      32'(bus.mix_in),      32'd0);
        check({tag, " m_valid"},     32'(bus.m_valid),     32'd0);
        check({tag, " m_i"},         32'(bus.m_i),         32'd0);
        check({tag, " m_q"},         32'(bus.m_q),         32'd0);
        check({tag, " cfg_pending"}, 32'(bus.cfg_pending), 32'd0);
        check({tag, " state"},       32'(bus.state_dbg),   32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic        sv;
        logic [15:0] sd;
        logic        ld;
        logic [31:0] fw;
        logic        clr;
        logic        rdy;
        logic        cos;
        logic [11:0] phs;
        logic [15:0] min;
        logic        mv;
        logic [15:0] mi;
        logic [15:0] mq;
        logic        pend;
    } vec_t;

    vec_t vecs[18];

    initial begin
        logic [15:0] d;

        //            sv   sd   ld  fw   clr  rdy cos  phs      min  mv   mi  mq  pend
        vecs[0]  = '{1'b0, 16'h0, 1'b1, F4,    1'b0, 1'b1, 1'b1, 12'd0,    16'h0, 1'b0, 16'h0, 16'h0, 1'b0};
        vecs[1]  = '{1'b0, 16'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 12'd0,    16'h0, 1'b0, 16'h0, 16'h0, 1'b1};
        vecs[2]  = '{1'b1, DV,    1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 12'd0,    16'h0, 1'b0, 16'h0, 16'h0, 1'b0};
        vecs[3]  = '{1'b1, DV,    1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 12'd0,    16'h0, 1'b0, 16'h0, 16'h0, 1'b0};
        vecs[4]  = '{1'b1, DV,    1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 12'd1024, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0};
        vecs[5]  = '{1'b1, DV,    1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 12'd1024, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0};
        vecs[6]  = '{1'b1, DV,    1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 12'd2048, DV,    1'b0, 16'h0, 16'h0, 1'b0};
        vecs[7]  = '{1'b1, DV,    1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 12'd2048, DV,    1'b0, 16'h0, 16'h0, 1'b0};
        vecs[8]  = '{1'b1, DV,    1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 12'd3072, DV,    1'b0, 16'h0, 16'h0, 1'b0};
        vecs[9]  = '{1'b0, 16'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 12'd3072, DV,    1'b0, PI,    16'h0, 1'b0};
        vecs[10] = '{1'b0, 16'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 12'd0,    DV,    1'b1, PI,    16'h0, 1'b0};
        vecs[11] = '{1'b0, 16'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 12'd0,    DV,    1'b0, 16'h0, 16'h0, 1'b0};
        vecs[12] = '{1'b0, 16'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 12'd0,    DV,    1'b1, 16'h0, PI,    1'b0};
        vecs[13] = '{1'b0, 16'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 12'd0,    DV,    1'b0, NI,    PI,    1'b0};
        vecs[14] = '{1'b0, 16'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 12'd0,    16'h0, 1'b1, NI,    16'h0, 1'b0};
        vecs[15] = '{1'b0, 16'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 12'd0,    16'h0, 1'b0, 16'h0, 16'h0, 1'b0};
        vecs[16] = '{1'b0, 16'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 12'd0,    16'h0, 1'b1, 16'h0, NI,    1'b0};
        vecs[17] = '{1'b0, 16'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 12'd0,    16'h0, 1'b0, 16'h0, NI,    1'b0};

        // ---------------- reset values ----------------
        bus.s_valid = 1'b0; bus.s_data = '0; bus.cfg_load = 1'b0;
        bus.cfg_fword = '0; bus.cfg_phase_clr = 1'b0; bus.enable = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // ---------------- quadrant stepping table ----------------
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].sv, vecs[i].sd, vecs[i].ld, vecs[i].fw, vecs[i].clr, 1'b1);
            check($sformatf("row%0d s_ready", i),     32'(bus.s_ready),     32'(vecs[i].rdy));
            check($sformatf("row%0d mix_cos", i),     32'(bus.mix_cos),     32'(vecs[i].cos));
            check($sformatf("row%0d mix_phs", i),     32'(bus.mix_phs),     32'(vecs[i].phs));
            check($sformatf("row%0d mix_in", i),      32'(bus.mix_in),      32'(vecs[i].min));
            check($sformatf("row%0d m_valid", i),     32'(bus.m_valid),     32'(vecs[i].mv));
            check($sformatf("row%0d m_i", i),         32'(bus.m_i),         32'(vecs[i].mi));
            check($sformatf("row%0d m_q", i),         32'(bus.m_q),         32'(vecs[i].mq));
            check($sformatf("row%0d cfg_pending", i), 32'(bus.cfg_pending), 32'(vecs[i].pend));
        end

        // ---------------- handshake and throughput ----------------
        // Accumulator has wrapped to 0 with fword_act = 0x4000_0000.
        sb_data  = 1'b1;
        exp_acc  = '0;
        mv_count = 0;
        for (int k = 0; k < 10; k++) begin
            d = 16'($urandom_range(0, 65535));
            drive(1'b1, d, 1'b0, 32'h0, 1'b0, 1'b1);
            check($sformatf("thr s_ready c%0d", k), 32'(bus.s_ready), 32'((k % 2) == 0));
            observe();
        end
        for (int k = 0; k < 12; k++) begin
            idle();
            observe();
        end
        check("thr m_valid count", 32'(mv_count), 32'd5);

        // ---------------- disable mid-stream ----------------
        mv_count = 0;
        for (int k = 0; k < 4; k++) begin
            d = 16'($urandom_range(1, 32767));
            drive(1'b1, d, 1'b0, 32'h0, 1'b0, 1'b1);
            observe();
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 16'h7777, 1'b0, 32'h0, 1'b0, 1'b0);
            check($sformatf("dis s_ready c%0d", k), 32'(bus.s_ready), 32'd0);
            observe();
        end
        for (int k = 0; k < 10; k++) begin
            idle();
            observe();
        end
        check("dis m_valid count", 32'(mv_count), 32'd2);

        // ---------------- reset mid-stream (at A+5) ----------------
        sb_data = 1'b0;
        drive(1'b1, 16'h1234, 1'b0, 32'h0, 1'b0, 1'b1);
        observe();
        for (int k = 0; k < 4; k++) begin
            idle();
            observe();
        end
        check("pre-reset mix_in", 32'(bus.mix_in), 32'h1234);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        exp_cyc_q.delete();
        exp_q.delete();
        mv_count = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            idle();
            observe();
        end
        check("midreset m_valid count", 32'(mv_count), 32'd0);

        // ---------------- load during ISSUE_Q, then clear+load ----------------
        drive(1'b0, 16'h0, 1'b1, F4, 1'b0, 1'b1);            // load while idle
        observe();
        idle();
        observe();
        check("ld idle pending", 32'(bus.cfg_pending), 32'd1);
        drive(1'b1, 16'h0100, 1'b0, 32'h0, 1'b0, 1'b1);      // sample, phase 0
        observe();
        check("ld s0 phs", 32'(bus.mix_phs), 32'd0);
        check("ld s0 pending", 32'(bus.cfg_pending), 32'd0);
        drive(1'b0, 16'h0, 1'b1, F2, 1'b0, 1'b1);            // load in ISSUE_Q
        observe();
        check("ld q state", 32'(bus.state_dbg), 32'd1);
        check("ld q pending", 32'(bus.cfg_pending), 32'd0);
        idle();
        observe();
        check("ld pend high", 32'(bus.cfg_pending), 32'd1);
        check("ld phs after old step", 32'(bus.mix_phs), 32'd1024);
        drive(1'b1, 16'h0100, 1'b0, 32'h0, 1'b0, 1'b1);
        observe();
        check("ld pend low again", 32'(bus.cfg_pending), 32'd0);
        check("ld s1 phs", 32'(bus.mix_phs), 32'd1024);
        idle();
        observe();
        drive(1'b1, 16'h0100, 1'b0, 32'h0, 1'b0, 1'b1);
        observe();
        check("ld s2 phs new step", 32'(bus.mix_phs), 32'd1536);
        drive(1'b0, 16'h0, 1'b1, F1, 1'b1, 1'b1);            // clear + load in ISSUE_Q
        observe();
        idle();
        observe();
        check("clr pend high", 32'(bus.cfg_pending), 32'd1);
        check("clr phs before apply", 32'(bus.mix_phs), 32'd2048);
        drive(1'b1, 16'h0100, 1'b0, 32'h0, 1'b0, 1'b1);
        observe();
        check("clr s0 phs", 32'(bus.mix_phs), 32'd0);
        check("clr pend low", 32'(bus.cfg_pending), 32'd0);
        idle();
        observe();
        drive(1'b1, 16'h0100, 1'b0, 32'h0, 1'b0, 1'b1);
        observe();
        check("clr s1 phs", 32'(bus.mix_phs), 32'd256);
        for (int k = 0; k < 12; k++) begin
            idle();
            observe();
        end

        checks++;
        if (exp_cyc_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard drain: got %0d outstanding expected 0", exp_cyc_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
